mr_ex: RTL

Execute/writeback stage of the mr core. Accepts one decoded operation per handshake from the decode stage's `alu_*` bus, performs the ALU operation, branch resolution or a single data-memory access, and returns exactly one writeback (`wb_valid`/`wb_reg`/`wb_val`) per accepted operation. It also returns one `jmp_done` pulse per accepted branch or jump, together with the fetch redirect, so decode can release its register-pending counters and its jump interlock.

---
 rtl/mr_pkg.sv | 64 ++++++
 rtl/mr_alu.sv | 47 ++++
 rtl/mr_ex.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mr_pkg.sv
// Shared definitions for the mr core: operand widths, opcode constants and the
// operation encodings passed from decode to the execute stage.
package mr_pkg;

   localparam int XLEN        = 32;
   localparam int REGSEL_BITS = 5;
   localparam int ALU_OP_BITS = 4;
   localparam int BR_OP_BITS  = 3;
   localparam int MEM_OP_BITS = 2;
   localparam int MEM_SZ_BITS = 2;

   localparam logic [6:0] RV_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] RV_OP_STORE  = 7'b0100011;
   localparam logic [6:0] RV_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] RV_OP_JALR   = 7'b1100111;
   localparam logic [6:0] RV_OP_JAL    = 7'b1101111;
   localparam logic [6:0] RV_OP_IMM    = 7'b0010011;
   localparam logic [6:0] RV_OP_REG    = 7'b0110011;

   typedef enum logic [ALU_OP_BITS-1:0] {
      ALU_ADD, ALU_SUB, ALU_CMP_LT, ALU_CMP_LTU, ALU_XOR,
      ALU_OR, ALU_AND, ALU_SH_L, ALU_SH_RL, ALU_SH_RA
   } alu_op_t;

   typedef enum logic [BR_OP_BITS-1:0] {
      BROP_NEVER, BROP_ALWAYS, BROP_EQ, BROP_NE,
      BROP_LT, BROP_GE, BROP_LTU, BROP_GEU
   } br_op_t;

   typedef enum logic [MEM_OP_BITS-1:0] {
      MEMOP_NONE, MEMOP_LOAD, MEMOP_STORE
   } mem_op_t;

   typedef enum logic [MEM_SZ_BITS-1:0] {
      MEMSZ_1B, MEMSZ_2B, MEMSZ_4B
   } mem_sz_t;

   typedef enum logic [1:0] {
      IDLE, EXEC, MEM, MEM_DONE
   } ex_state_t;

   function automatic logic misaligned(input mem_sz_t sz, input logic [1:0] lo);
      case (sz)
         MEMSZ_1B: return 1'b0;
         MEMSZ_2B: return lo[0];
         default:  return lo != 2'b00;
      endcase
   endfunction

   // Pick the addressed byte/half out of the bus word and extend it.
   function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] w,
                                                    input mem_sz_t sz,
                                                    input logic [1:0] lo,
                                                    input logic sgn);
      logic [XLEN-1:0] sh;
      sh = w >> {lo, 3'b000};
      case (sz)
         MEMSZ_1B: return {{(XLEN-8){sgn & sh[7]}}, sh[7:0]};
         MEMSZ_2B: return {{(XLEN-16){sgn & sh[15]}}, sh[15:0]};
         default:  return w;
      endcase
   endfunction

endpackage

// File: rtl/mr_alu.sv
// Combinational ALU plus branch-condition evaluation for the execute stage.
module mr_alu import mr_pkg::*; (
   input  logic [ALU_OP_BITS-1:0] op,
   input  logic [XLEN-1:0]        a,
   input  logic [XLEN-1:0]        b,
   input  logic [BR_OP_BITS-1:0]  br_op,
   input  logic [XLEN-1:0]        p1,
   input  logic [XLEN-1:0]        p2,
   output logic [XLEN-1:0]        res,
   output logic                   cond
);

   logic [4:0] shamt;
   assign shamt = b[4:0];

   always_comb begin
      res = '0;
      case (alu_op_t'(op))
         ALU_ADD:     res = a + b;
         ALU_SUB:     res = a - b;
         ALU_CMP_LT:  res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         ALU_CMP_LTU: res = {{(XLEN-1){1'b0}}, a < b};
         ALU_XOR:     res = a ^ b;
         ALU_OR:      res = a | b;
         ALU_AND:     res = a & b;
         ALU_SH_L:    res = a << shamt;
         ALU_SH_RL:   res = a >> shamt;
         ALU_SH_RA:   res = $unsigned($signed(a) >>> shamt);
         default:     res = '0;
      endcase
   end

   always_comb begin
      cond = 1'b0;
      case (br_op_t'(br_op))
         BROP_ALWAYS: cond = 1'b1;
         BROP_EQ:     cond = p1 == p2;
         BROP_NE:     cond = p1 != p2;
         BROP_LT:     cond = $signed(p1) < $signed(p2);
         BROP_GE:     cond = $signed(p1) >= $signed(p2);
         BROP_LTU:    cond = p1 < p2;
         BROP_GEU:    cond = p1 >= p2;
         default:     cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/mr_ex.sv
// Execute/writeback stage: one op per handshake, ALU or branch or a single
// data-memory access, always retiring exactly one writeback per accepted op.
module mr_ex import mr_pkg::*; (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   alu_valid,
   output logic                   alu_ready,
   input  logic [XLEN-1:0]        alu_arg1,
   input  logic [XLEN-1:0]        alu_arg2,
   input  logic [REGSEL_BITS-1:0] alu_dst,
   input  logic [ALU_OP_BITS-1:0] alu_aluop,
   input  logic [BR_OP_BITS-1:0]  alu_br_op,
   input  logic [MEM_OP_BITS-1:0] alu_memop,
   input  logic [MEM_SZ_BITS-1:0] alu_size,
   input  logic                   alu_signed,
   input  logic [XLEN-1:0]        alu_payload,
   input  logic [XLEN-1:0]        alu_payload2,
   output logic                   wb_valid,
   output logic [REGSEL_BITS-1:0] wb_reg,
   output logic [XLEN-1:0]        wb_val,
   output logic                   jmp_done,
   output logic                   br_taken,
   output logic [XLEN-1:0]        br_target,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [XLEN-1:0]        mem_addr,
   output logic [XLEN-1:0]        mem_wdata,
   output logic [3:0]             mem_wstrb,
   input  logic                   mem_ack,
   input  logic [XLEN-1:0]        mem_rdata,
   output logic                   misalign_err
);

   ex_state_t       state;
   logic [XLEN-1:0] alu_res;
   logic            alu_cond;
   mem_op_t         mop_in;
   mem_sz_t         sz_in;
   logic            is_mem;
   logic            is_br;
   logic            is_mis;
   logic [XLEN-1:0] wdata_in;
   logic [3:0]      wstrb_in;
   logic [1:0]      ld_lo;
   mem_sz_t         ld_size;
   logic            ld_signed;
   logic            ld_load;

   mr_alu alu (
      .op    (alu_aluop),
      .a     (alu_arg1),
      .b     (alu_arg2),
      .br_op (alu_br_op),
      .p1    (alu_payload),
      .p2    (alu_payload2),
      .res   (alu_res),
      .cond  (alu_cond)
   );

   assign alu_ready = !rst && state == IDLE;
   assign mop_in    = mem_op_t'(alu_memop);
   assign sz_in     = mem_sz_t'(alu_size);
   assign is_mem    = mop_in != MEMOP_NONE;
   assign is_br     = !is_mem && br_op_t'(alu_br_op) != BROP_NEVER;
   assign is_mis    = is_mem && misaligned(sz_in, alu_res[1:0]);

   // Stores replicate the payload across all lanes; the strobe picks the live ones.
   always_comb begin
      wdata_in = alu_payload;
      wstrb_in = 4'b1111;
      case (sz_in)
         MEMSZ_1B: begin
            wdata_in = {4{alu_payload[7:0]}};
            wstrb_in = 4'b0001 << alu_res[1:0];
         end
         MEMSZ_2B: begin
            wdata_in = {2{alu_payload[15:0]}};
            wstrb_in = 4'b0011 << alu_res[1:0];
         end
         default: begin
            wdata_in = alu_payload;
            wstrb_in = 4'b1111;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         wb_valid     <= 1'b0;
         wb_reg       <= '0;
         wb_val       <= '0;
         jmp_done     <= 1'b0;
         br_taken     <= 1'b0;
         br_target    <= '0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_wstrb    <= 4'b0000;
         misalign_err <= 1'b0;
         ld_lo        <= 2'b00;
         ld_size      <= MEMSZ_1B;
         ld_signed    <= 1'b0;
         ld_load      <= 1'b0;
      end else begin
         wb_valid     <= 1'b0;
         jmp_done     <= 1'b0;
         br_taken     <= 1'b0;
         misalign_err <= 1'b0;
         case (state)
            IDLE: begin
               if (alu_valid) begin
                  wb_reg    <= alu_dst;
                  ld_lo     <= alu_res[1:0];
                  ld_size   <= sz_in;
                  ld_signed <= alu_signed;
                  ld_load   <= mop_in == MEMOP_LOAD;
                  if (is_mem && !is_mis) begin
                     mem_req   <= 1'b1;
                     mem_we    <= mop_in == MEMOP_STORE;
                     mem_addr  <= {alu_res[XLEN-1:2], 2'b00};
                     mem_wdata <= wdata_in;
                     mem_wstrb <= wstrb_in;
                     state     <= MEM;
                  end else begin
                     // Misaligned accesses retire like a plain op, with a zero result.
                     wb_valid     <= 1'b1;
                     misalign_err <= is_mis;
                     jmp_done     <= is_br;
                     br_taken     <= is_br && alu_cond;
                     br_target    <= {alu_res[XLEN-1:1], 1'b0};
                     if (is_mem)
                        wb_val <= '0;
                     else if (br_op_t'(alu_br_op) == BROP_ALWAYS)
                        wb_val <= alu_payload + XLEN'(4);
                     else
                        wb_val <= alu_res;
                     state <= EXEC;
                  end
               end
            end
            EXEC: state <= IDLE;
            MEM: begin
               if (mem_ack) begin
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_wstrb <= 4'b0000;
                  wb_valid  <= 1'b1;
                  wb_val    <= ld_load ? load_extract(mem_rdata, ld_size, ld_lo, ld_signed) : '0;
                  state     <= MEM_DONE;
               end
            end
            MEM_DONE: state <= IDLE;
            default:  state <= IDLE;
         endcase
      end
   end

endmodule
